// File: rtl/host_burst_rd_ctrl.sv
// Host read-request sequencer: latches a start address and word count from host strobes,
// then issues the transfer to the SDRAM read port as bursts of at most BURST words.
module host_burst_rd_ctrl #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 10,
    parameter int BURST  = 8,
    parameter int BLEN_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_laddr,
    input  logic              cs_haddr,
    input  logic              cs_row,
    input  logic [15:0]       host_data,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [BLEN_W-1:0] sd_len,
    output logic              sd_req,
    input  logic              sd_ack,
    output logic              hrd_req,
    output logic              done,
    output logic              cmd_err
);
    localparam int CMP_W = (LEN_W > BLEN_W) ? LEN_W : BLEN_W;
    localparam logic [CMP_W-1:0] BURST_C = CMP_W'(BURST);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [BLEN_W-1:0] sd_len_q, sd_len_d;
    logic              sd_req_q, sd_req_d;
    logic              hrd_req_q, hrd_req_d;
    logic              done_q, done_d;
    logic              cmd_err_q, cmd_err_d;
    logic              cs_l_q, cs_l_d, cs_h_q, cs_h_d, cs_r_q, cs_r_d;
    logic              cs_l_p_q, cs_l_p_d, cs_h_p_q, cs_h_p_d, cs_r_p_q, cs_r_p_d;
    logic [15:0]       data_q, data_d;

    logic              ev_l, ev_h, ev_r;
    logic [LEN_W-1:0]  row_n;
    logic [CMP_W-1:0]  rem_ext, len_ext, rem_left;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        sd_addr_d = sd_addr_q;
        sd_len_d  = sd_len_q;
        sd_req_d  = sd_req_q;
        hrd_req_d = hrd_req_q;
        done_d    = 1'b0;
        cmd_err_d = 1'b0;
        cs_l_d    = cs_laddr;
        cs_h_d    = cs_haddr;
        cs_r_d    = cs_row;
        cs_l_p_d  = cs_l_q;
        cs_h_p_d  = cs_h_q;
        cs_r_p_d  = cs_r_q;
        // host_data is registered alongside the strobes so the event sees the matching word
        data_d    = host_data;

        ev_l      = cs_l_p_q & ~cs_l_q;
        ev_h      = cs_h_p_q & ~cs_h_q;
        ev_r      = cs_r_p_q & ~cs_r_q;
        row_n     = data_q[LEN_W-1:0];
        rem_ext   = CMP_W'(rem_q);
        len_ext   = CMP_W'(sd_len_q);
        rem_left  = rem_ext - len_ext;

        if (state_q != ST_IDLE && (ev_l || ev_h || ev_r)) begin
            cmd_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ev_l) begin
                    addr_d[15:0] = data_q;
                end else if (ev_h) begin
                    addr_d[ADDR_W-1:16] = data_q[ADDR_W-17:0];
                end else if (ev_r) begin
                    rem_d = row_n;
                    if (row_n != '0) begin
                        hrd_req_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                sd_len_d  = (rem_ext < BURST_C) ? BLEN_W'(rem_ext) : BLEN_W'(BURST_C);
                sd_addr_d = addr_q;
                sd_req_d  = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (sd_ack) begin
                    sd_req_d = 1'b0;
                    addr_d   = addr_q + ADDR_W'(sd_len_q);
                    rem_d    = LEN_W'(rem_left);
                    if (rem_left == '0) begin
                        hrd_req_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            sd_addr_q <= '0;
            sd_len_q  <= '0;
            sd_req_q  <= 1'b0;
            hrd_req_q <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            cs_l_q    <= 1'b1;
            cs_h_q    <= 1'b1;
            cs_r_q    <= 1'b1;
            cs_l_p_q  <= 1'b1;
            cs_h_p_q  <= 1'b1;
            cs_r_p_q  <= 1'b1;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            sd_addr_q <= sd_addr_d;
            sd_len_q  <= sd_len_d;
            sd_req_q  <= sd_req_d;
            hrd_req_q <= hrd_req_d;
            done_q    <= done_d;
            cmd_err_q <= cmd_err_d;
            cs_l_q    <= cs_l_d;
            cs_h_q    <= cs_h_d;
            cs_r_q    <= cs_r_d;
            cs_l_p_q  <= cs_l_p_d;
            cs_h_p_q  <= cs_h_p_d;
            cs_r_p_q  <= cs_r_p_d;
            data_q    <= data_d;
        end
    end

    assign sd_addr = sd_addr_q;
    assign sd_len  = sd_len_q;
    assign sd_req  = sd_req_q;
    assign hrd_req = hrd_req_q;
    assign done    = done_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_host_burst_rd_ctrl.sv
// Bench for host_burst_rd_ctrl: transfer-level model pushes expected bursts/pulses into
// queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_host_burst_rd_ctrl;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;
    localparam int BURST  = 8;
    localparam int BLEN_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs_laddr, cs_haddr, cs_row;
    logic [15:0]       host_data;
    logic [ADDR_W-1:0] sd_addr;
    logic [BLEN_W-1:0] sd_len;
    logic              sd_req;
    logic              sd_ack;
    logic              hrd_req, done, cmd_err;

    host_burst_rd_ctrl #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST(BURST), .BLEN_W(BLEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cs_laddr(cs_laddr), .cs_haddr(cs_haddr), .cs_row(cs_row),
        .host_data(host_data),
        .sd_addr(sd_addr), .sd_len(sd_len), .sd_req(sd_req), .sd_ack(sd_ack),
        .hrd_req(hrd_req), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int               bq_addr[$];
    int               bq_len[$];
    int               exp_done = 0;
    int               exp_err  = 0;
    logic [ADDR_W-1:0] m_addr = '0;

    int ack_delay = -1;
    bit ack_en    = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every DUT-presented event is matched against the queued expectations.
    logic prev_req = 1'b0;
    int   cur_a = 0;
    int   cur_l = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (sd_req && !prev_req) begin
                if (bq_addr.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_burst: got addr 0x%0h len %0d, expected no burst", sd_addr, sd_len);
                end else begin
                    cur_a = bq_addr.pop_front();
                    cur_l = bq_len.pop_front();
                    check("burst_addr", 32'(sd_addr), 32'(cur_a));
                    check("burst_len", 32'(sd_len), 32'(cur_l));
                    check("hrd_req_busy", 32'(hrd_req), 32'd1);
                end
            end else if (sd_req) begin
                check("hold_addr", 32'(sd_addr), 32'(cur_a));
                check("hold_len", 32'(sd_len), 32'(cur_l));
            end
            if (done) begin
                if (exp_done == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    exp_done--;
                    check("hrd_req_at_done", 32'(hrd_req), 32'd0);
                end
            end
            if (cmd_err) begin
                if (exp_err == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_cmd_err: got cmd_err=1, expected 0");
                end else begin
                    exp_err--;
                end
            end
            prev_req = sd_req;
        end
    end

    // SDRAM-side responder
    initial begin
        int d;
        sd_ack = 1'b0;
        forever begin
            tick();
            if (!rst && ack_en && sd_req && !sd_ack) begin
                d = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
                repeat (d) tick();
                sd_ack = 1'b1;
                tick();
                sd_ack = 1'b0;
            end
        end
    end

    task automatic cs_pulse(input bit l, input bit h, input bit r, input logic [15:0] d, input int hold);
        tick();
        cs_laddr  = ~l;
        cs_haddr  = ~h;
        cs_row    = ~r;
        host_data = d;
        repeat (hold) tick();
        cs_laddr  = 1'b1;
        cs_haddr  = 1'b1;
        cs_row    = 1'b1;
        host_data = 16'($urandom);
        tick();
    endtask

    task automatic do_laddr(input logic [15:0] d);
        m_addr[15:0] = d;
        cs_pulse(1'b1, 1'b0, 1'b0, d, 1);
    endtask

    task automatic do_haddr(input logic [15:0] d);
        m_addr[ADDR_W-1:16] = d[ADDR_W-17:0];
        cs_pulse(1'b0, 1'b1, 1'b0, d, 1);
    endtask

    // Transfer model: split N words into BURST-sized chunks from the running address.
    task automatic do_row(input int n, input int hold);
        int left;
        int len;
        logic [15:0] d;
        left = n;
        while (left > 0) begin
            len = (left < BURST) ? left : BURST;
            bq_addr.push_back(int'(m_addr));
            bq_len.push_back(len);
            m_addr = m_addr + ADDR_W'(len);
            left   = left - len;
        end
        exp_done++;
        d = 16'($urandom);
        d[LEN_W-1:0] = LEN_W'(n);
        cs_pulse(1'b0, 1'b0, 1'b1, d, hold);
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (bq_addr.size() == 0 && exp_done == 0 && exp_err == 0 && !sd_req) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d bursts/%0d done/%0d err outstanding, expected 0",
                     nm, bq_addr.size(), exp_done, exp_err);
            bq_addr.delete();
            bq_len.delete();
            exp_done = 0;
            exp_err  = 0;
        end
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        cs_laddr  = 1'b1;
        cs_haddr  = 1'b1;
        cs_row    = 1'b1;
        host_data = 16'h0;
        repeat (3) tick();
        check("rst_sd_addr", 32'(sd_addr), 32'd0);
        check("rst_sd_len", 32'(sd_len), 32'd0);
        check("rst_sd_req", 32'(sd_req), 32'd0);
        check("rst_hrd_req", 32'(hrd_req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst    = 1'b0;
        ack_en = 1'b1;
        tick();

        // Basic three-burst transfer, acks three cycles late
        ack_delay = 3;
        do_laddr(16'h1234);
        do_haddr(16'h0056);
        do_row(20, 1);
        wait_idle("row20");

        // Zero-length command
        do_row(0, 1);
        for (int i = 0; i < 4; i++) check("hrd_req_n0", 32'(hrd_req), 32'd0);
        wait_idle("row0");

        // Address wrap; haddr upper bits beyond ADDR_W are ignored
        ack_delay = -1;
        do_laddr(16'hFFFC);
        do_haddr(16'hABFF);
        do_row(8, 1);
        wait_idle("wrap8");
        do_row(1, 1);
        wait_idle("wrap1");

        // Held-low strobe yields one command
        ack_delay = 3;
        do_row(8, 50);
        wait_idle("held");

        // Rejected row and laddr while waiting for ack
        ack_delay = 20;
        do_row(8, 1);
        repeat (4) tick();
        exp_err++;
        cs_pulse(1'b0, 1'b0, 1'b1, 16'h0008, 1);
        exp_err++;
        cs_pulse(1'b1, 1'b0, 1'b0, 16'h5555, 1);
        wait_idle("busy_err");

        // laddr and row together: address loaded, row dropped
        ack_delay = -1;
        m_addr[15:0] = 16'h0BEE;
        cs_pulse(1'b1, 1'b0, 1'b1, 16'h0BEE, 2);
        repeat (6) tick();
        check("simul_no_req", 32'(sd_req), 32'd0);
        check("simul_no_hrd", 32'(hrd_req), 32'd0);
        do_row(2, 1);
        wait_idle("simul_follow");

        // Randomised commands
        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(0, 1) == 1) do_laddr(16'($urandom));
            if ($urandom_range(0, 1) == 1) do_haddr(16'($urandom));
            do_row(int'($urandom_range(0, 40)), int'($urandom_range(1, 4)));
            wait_idle("rand");
        end

        // Reset while a request is outstanding
        ack_en = 1'b0;
        do_row(16, 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sd_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("rst_mid_req_seen", 32'(ok), 32'd1);
        rst = 1'b1;
        bq_addr.delete();
        bq_len.delete();
        exp_done = 0;
        tick();
        check("rst_mid_sd_req", 32'(sd_req), 32'd0);
        check("rst_mid_hrd_req", 32'(hrd_req), 32'd0);
        check("rst_mid_sd_addr", 32'(sd_addr), 32'd0);
        check("rst_mid_sd_len", 32'(sd_len), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        repeat (8) tick();
        check("post_rst_sd_req", 32'(sd_req), 32'd0);
        check("post_rst_hrd_req", 32'(hrd_req), 32'd0);

        // Recovery after reset
        ack_en    = 1'b1;
        ack_delay = -1;
        do_laddr(16'h4000);
        do_haddr(16'h0012);
        do_row(11, 1);
        wait_idle("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
